mem_swap_engine: RTL and testbench

//  Parametrised register-file with built-in swap engine: exchanges two entries on a req/ready

---
 rtl/swap_pkg.sv | 12 +
 rtl/mem_swap_engine_if.sv | 32 +++
 rtl/swap_mem_array.sv | 22 ++
 rtl/mem_swap_engine.sv | 157 +++++++++++++++
 tb/tb_mem_swap_engine.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/swap_pkg.sv
// Shared definitions for the swap engine: FSM state encoding and default geometry.
package swap_pkg;
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WR_A = 2'd2,
        WR_B = 2'd3
    } swap_state_t;
endpackage

// File: rtl/mem_swap_engine_if.sv
// Bus bundle for mem_swap_engine: swap handshake/status plus the single-ported user read/write path.
interface mem_swap_engine_if
    import swap_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              swap_req;
    logic              swap_ready;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic              swap_busy;
    logic              swap_done;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              err_drop;

    modport master (
        output swap_req, addr_a, addr_b, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  swap_ready, swap_busy, swap_done, rd_data, rd_valid, err_drop
    );

    modport slave (
        input  swap_req, addr_a, addr_b, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output swap_ready, swap_busy, swap_done, rd_data, rd_valid, err_drop
    );
endinterface

// File: rtl/swap_mem_array.sv
// Storage for the swap engine: one synchronous write port, one asynchronous read port, no reset.
module swap_mem_array
    import swap_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/mem_swap_engine.sv
// Register file with a two-entry swap engine arbitrating against a user read/write port.
// Optional SWAP_PENDING_EN adds a one-entry request slot for back-to-back swaps.
//
//  state | meaning
//  IDLE  | user port live, swap requests accepted
//  LOAD  | tmp <= mem[a]; a==b finishes here with no writes
//  WR_A  | mem[a] <= mem[b]
//  WR_B  | mem[b] <= tmp; swap complete
module mem_swap_engine
    import swap_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rstn,
    mem_swap_engine_if.slave   bus
);
    swap_state_t       state, state_nx;
    logic [ADDR_W-1:0] a_q, b_q, nxt_a, nxt_b;
    logic [DATA_W-1:0] tmp;
    logic              done_q, rd_valid_q, err_drop_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              accept, load_next, done_set, pend_take;

`ifdef SWAP_PENDING_EN
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_a, pend_b;
    assign bus.swap_ready = (state == IDLE) || !pend_valid;
`else
    assign bus.swap_ready = (state == IDLE);
`endif

    assign accept        = bus.swap_req && bus.swap_ready;
    assign bus.swap_busy = (state != IDLE);
    assign bus.swap_done = done_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.err_drop  = err_drop_q;

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        mem_raddr = bus.rd_addr;
        load_next = 1'b0;
        nxt_a     = bus.addr_a;
        nxt_b     = bus.addr_b;
        done_set  = 1'b0;
        pend_take = 1'b0;
        case (state)
            IDLE: begin
                mem_we = bus.wr_en;
                if (accept) begin
                    state_nx  = LOAD;
                    load_next = 1'b1;
                end
            end
            LOAD: begin
                mem_raddr = a_q;
                if (a_q == b_q) begin
                    state_nx = IDLE;
                    done_set = 1'b1;
                end else begin
                    state_nx = WR_A;
                end
            end
            WR_A: begin
                mem_raddr = b_q;
                mem_we    = 1'b1;
                mem_waddr = a_q;
                mem_wdata = mem_rdata;
                state_nx  = WR_B;
            end
            WR_B: begin
                mem_we    = 1'b1;
                mem_waddr = b_q;
                mem_wdata = tmp;
                state_nx  = IDLE;
                done_set  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
`ifdef SWAP_PENDING_EN
        // Chain straight into the next swap so the user port never sees an IDLE gap.
        if (done_set) begin
            if (pend_valid) begin
                state_nx  = LOAD;
                load_next = 1'b1;
                pend_take = 1'b1;
                nxt_a     = pend_a;
                nxt_b     = pend_b;
            end else if (accept) begin
                state_nx  = LOAD;
                load_next = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            err_drop_q <= 1'b0;
            rd_data_q  <= '0;
`ifdef SWAP_PENDING_EN
            pend_valid <= 1'b0;
`endif
        end else begin
            done_q     <= done_set;
            rd_valid_q <= (state == IDLE) && bus.rd_en;
            err_drop_q <= (state != IDLE) && (bus.rd_en || bus.wr_en);
            if ((state == IDLE) && bus.rd_en) rd_data_q <= mem_rdata;
`ifdef SWAP_PENDING_EN
            if (pend_take)
                pend_valid <= 1'b0;
            else if (accept && (state != IDLE) && !done_set)
                pend_valid <= 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (load_next) begin
            a_q <= nxt_a;
            b_q <= nxt_b;
        end
        if (state == LOAD) tmp <= mem_rdata;
`ifdef SWAP_PENDING_EN
        if (accept && (state != IDLE) && !done_set) begin
            pend_a <= bus.addr_a;
            pend_b <= bus.addr_b;
        end
`endif
    end

    // A reset landing mid-swap must not let the in-flight write through.
    swap_mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
        .clk   (clk),
        .we    (mem_we && rstn && (pend_take || !pend_take)),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );
endmodule

// File: tb/tb_mem_swap_engine.sv
// Directed self-checking bench for mem_swap_engine; exercises the pending slot when SWAP_PENDING_EN is set.
module tb_mem_swap_engine;
    import swap_pkg::*;

    localparam int AW = 7;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   wcount = 0;
    int   n, w0;

    mem_swap_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_swap_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dut.u_array.we) wcount <= wcount + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        bus.rd_en = 1'b1; bus.rd_addr = addr;
        tick();
        bus.rd_en = 1'b0;
        chk({tag, "_valid"}, {31'd0, bus.rd_valid}, 32'd1);
        chk(tag, {24'd0, bus.rd_data}, {24'd0, exp});
    endtask

    task automatic swap_accept(input logic [AW-1:0] a, input logic [AW-1:0] b);
        bus.swap_req = 1'b1; bus.addr_a = a; bus.addr_b = b;
        tick();
        bus.swap_req = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.swap_done && cyc < 20);
        if (!bus.swap_done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bus.swap_req = 0; bus.addr_a = '0; bus.addr_b = '0;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_en = 0; bus.rd_addr = '0;

        tick(); tick();
        chk("rst_busy",  {31'd0, bus.swap_busy},  32'd0);
        chk("rst_done",  {31'd0, bus.swap_done},  32'd0);
        chk("rst_rdv",   {31'd0, bus.rd_valid},   32'd0);
        chk("rst_drop",  {31'd0, bus.err_drop},   32'd0);
        chk("rst_rdata", {24'd0, bus.rd_data},    32'd0);
        chk("rst_ready", {31'd0, bus.swap_ready}, 32'd1);
        rstn = 1'b1;
        tick();

        // basic swap 3<->9 with a dropped read during WR_A
        do_write(7'd3, 8'hAA);
        do_write(7'd9, 8'h55);
        swap_accept(7'd3, 7'd9);
        chk("load_busy", {31'd0, bus.swap_busy}, 32'd1);
`ifdef SWAP_PENDING_EN
        chk("load_ready", {31'd0, bus.swap_ready}, 32'd1);
`else
        chk("load_ready", {31'd0, bus.swap_ready}, 32'd0);
`endif
        tick();
        bus.rd_en = 1'b1; bus.rd_addr = 7'd3;
        tick();
        bus.rd_en = 1'b0;
        chk("drop_rd",  {31'd0, bus.err_drop}, 32'd1);
        chk("drop_rdv", {31'd0, bus.rd_valid}, 32'd0);
        wait_done(n);
        chk("swap_lat", n + 2, 32'd3);
        tick();
        chk("done_pulse", {31'd0, bus.swap_done}, 32'd0);
        chk("idle_drop", {31'd0, bus.err_drop}, 32'd0);
        do_read("m3_a", 7'd3, 8'h55);
        do_read("m9_a", 7'd9, 8'hAA);

        // a==b short path
        do_write(7'd5, 8'h11);
        swap_accept(7'd5, 7'd5);
        w0 = wcount;
        wait_done(n);
        chk("same_lat", n, 32'd1);
        chk("same_writes", wcount - w0, 32'd0);
        do_read("m5", 7'd5, 8'h11);

        // write and swap accepted on the same edge
        bus.wr_en = 1'b1; bus.wr_addr = 7'd3; bus.wr_data = 8'h77;
        swap_accept(7'd3, 7'd9);
        bus.wr_en = 1'b0;
        wait_done(n);
        chk("wrsw_lat", n, 32'd3);
        do_read("m3_b", 7'd3, 8'hAA);
        do_read("m9_b", 7'd9, 8'h77);

        // same-edge write and read of one address returns old data
        do_write(7'd20, 8'h10);
        bus.wr_en = 1'b1; bus.wr_addr = 7'd20; bus.wr_data = 8'h20;
        do_read("wr_rd_old", 7'd20, 8'h10);
        bus.wr_en = 1'b0;
        do_read("wr_rd_new", 7'd20, 8'h20);

        // dropped write while busy
        do_write(7'd1, 8'h01);
        do_write(7'd2, 8'h02);
        swap_accept(7'd1, 7'd2);
        do_write(7'd1, 8'hFF);
        chk("drop_wr", {31'd0, bus.err_drop}, 32'd1);
        wait_done(n);
        do_read("m1", 7'd1, 8'h02);
        do_read("m2", 7'd2, 8'h01);

        // reset in WR_B leaves a partial swap
        do_write(7'd3, 8'hAA);
        do_write(7'd9, 8'h55);
        swap_accept(7'd3, 7'd9);
        tick();
        tick();
        rstn = 1'b0;
        tick();
        chk("abort_done",  {31'd0, bus.swap_done},  32'd0);
        chk("abort_busy",  {31'd0, bus.swap_busy},  32'd0);
        chk("abort_ready", {31'd0, bus.swap_ready}, 32'd1);
        rstn = 1'b1;
        tick();
        chk("abort_done2", {31'd0, bus.swap_done}, 32'd0);
        do_read("m3_c", 7'd3, 8'h55);
        do_read("m9_c", 7'd9, 8'h55);

`ifdef SWAP_PENDING_EN
        // second request queued during the first swap
        do_write(7'd4, 8'h44);
        do_write(7'd6, 8'h66);
        swap_accept(7'd1, 7'd2);
        swap_accept(7'd4, 7'd6);
        chk("pend_ready", {31'd0, bus.swap_ready}, 32'd0);
        wait_done(n);
        chk("pend_lat1", n, 32'd2);
        wait_done(n);
        chk("pend_lat2", n, 32'd3);
        tick();
        do_read("m4", 7'd4, 8'h66);
        do_read("m6", 7'd6, 8'h44);
        do_read("m1_p", 7'd1, 8'h01);
        do_read("m2_p", 7'd2, 8'h02);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
